pixel_tx_framer: RTL and testbench
==================================

Name: pixel_tx_framer

Overview:
Transmit-side counterpart of the pixel receive path. It takes a row/column/value triple and emits it as a framed 5-byte stream (SOF, row, col, val, checksum) over a byte-wide valid/ready interface to the UART transmitter. That stream is the format the receive-side parser reassembles into the 24-bit pixel packet. After each frame it enforces a programmable inter-frame gap.

Parameters:
SOF_BYTE, 8'hA5, start-of-frame marker, first byte of every frame
GAP_CYCLES, 16, idle clock cycles enforced after each completed frame (0 = no gap)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
send_en  in  1  transmit enable; low blocks new frames and aborts an in-flight frame at the next byte boundary
send_req  in  1  single-cycle request to send one frame
row_index  in  8  pixel row, sampled on accepted request
col_index  in  8  pixel column, sampled on accepted request
pixel_val  in  8  pixel value, sampled on accepted request
tx_data  out  8  byte to UART transmitter
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART transmitter accepts byte
busy  out  1  high from request acceptance until the gap completes or the frame aborts
frame_done  out  1  one-cycle pulse after the checksum byte is accepted
frame_abort  out  1  one-cycle pulse when a frame is abandoned because send_en is low
led_tx_on  out  1  mirrors send_en (combinational)

Behaviour:
- Clock and reset: all state on posedge clk. Reset is synchronous, active-high.
- Reset values: state=ST_IDLE, tx_data=8'h00, tx_valid=0, busy=0, frame_done=0, frame_abort=0, gap counter=0.
- Registered outputs: all outputs except led_tx_on are registered.
- States: ST_IDLE, ST_SOF, ST_ROW, ST_COL, ST_VAL, ST_CSUM, ST_GAP.
- Request acceptance: in ST_IDLE, send_req && send_en latches row/col/val and computes csum = SOF_BYTE ^ row ^ col ^ val.
  - Next cycle: ST_SOF, tx_valid=1, tx_data=SOF_BYTE, busy=1.
  - Latency from request to first valid byte is 1 cycle.
- Ignored requests: send_req with send_en low is ignored. send_req in any state other than ST_IDLE is ignored and not queued.
- Handshake: a byte transfers on a cycle where tx_valid && tx_ready.
  - The next byte appears on the following cycle with tx_valid held high, so a continuously ready sink sees 5 back-to-back bytes.
  - Once tx_valid is high, tx_valid and tx_data hold stable until the handshake, regardless of send_en.
- Byte order: SOF -> row -> col -> val -> csum.
- Frame completion: on the csum handshake, the next cycle has tx_valid=0 and frame_done=1 for one cycle.
  - State goes to ST_GAP and the counter loads GAP_CYCLES-1. busy stays high.
  - busy drops the cycle after the counter reaches 0, and the state returns to ST_IDLE.
  - With GAP_CYCLES=0, the state goes straight to ST_IDLE and busy drops with frame_done.
- Abort: on a handshake of SOF, row, col or val with send_en=0, the next cycle has tx_valid=0 and frame_abort=1 for one cycle. State goes to ST_IDLE, busy=0, and no gap is applied.
  - send_en low during the csum handshake does not abort; the frame completes normally.
- Input stability: changes on row/col/val after acceptance do not affect the in-flight frame.
- Reset mid-frame: the next edge returns to reset values and the partial frame is abandoned without a frame_abort pulse.
- Width rules: checksum is an 8-bit XOR with no carry. The gap counter width is $clog2(GAP_CYCLES+1), minimum 1.

Decomposition:
- Package pixel_tx_pkg:
  - state_t enum (3-bit)
  - default SOF constant 8'hA5
  - pure function frame_csum(sof,row,col,val)
  - The receive-side parser imports the same package for SOF and checksum.
- No sub-module: a single module with a next-state always_comb, a state/output always_ff and a gap counter always_ff.

Test Plan:
1. send_req with row=0x12, col=0x34, val=0x56, tx_ready=1 constant -> tx_data sequence A5,12,34,56,D5 on 5 consecutive cycles starting 1 cycle after the request. frame_done pulses the next cycle. busy stays high 16 further cycles, then drops.
2. Same frame, tx_ready held low 3 cycles while the row byte is presented -> tx_data stays 0x12 and tx_valid stays 1 for all 4 cycles. Total frame length is 8 cycles and the bytes are unchanged.
3. send_en dropped at the col handshake -> next cycle tx_valid=0, frame_abort=1, busy=0. A new send_req with send_en=1 is accepted immediately and starts with A5.
4. Second send_req issued during the gap, and another mid-frame -> both ignored. Exactly one frame is emitted, and no request is accepted until busy=0.
5. reset asserted during the val byte -> next cycle all outputs are at reset values, with no frame_done or frame_abort pulse.
6. GAP_CYCLES=0 build, two requests 6 cycles apart with row=0xFF, col=0x00, val=0xFF -> two frames A5,FF,00,FF,A5. busy falls with frame_done.

Source files
------------

// File: rtl/pixel_tx_pkg.sv
// pixel_tx_pkg: types and helpers shared by the pixel transmit framer and the
// receive-side parser, so both ends agree on the start marker and checksum.
//   state_t     - framer FSM state encoding (3 bits)
//   SOF_DEFAULT - default start-of-frame marker
//   frame_csum  - 8-bit XOR checksum over SOF, row, col and value
package pixel_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SOF  = 3'd1,
        ST_ROW  = 3'd2,
        ST_COL  = 3'd3,
        ST_VAL  = 3'd4,
        ST_CSUM = 3'd5,
        ST_GAP  = 3'd6
    } state_t;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    function automatic logic [7:0] frame_csum(input logic [7:0] sof,
                                              input logic [7:0] row,
                                              input logic [7:0] col,
                                              input logic [7:0] val);
        return sof ^ row ^ col ^ val;
    endfunction

endpackage

// File: rtl/pixel_tx_framer_if.sv
// pixel_tx_framer_if: byte-wide valid/ready stream towards the UART transmitter.
//   tx_data  - byte being offered
//   tx_valid - tx_data is valid
//   tx_ready - sink accepts the byte this cycle
// master = framer side, slave = UART transmitter side.
interface pixel_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pixel_tx_framer.sv
// pixel_tx_framer: frames a row/column/value triple as SOF, row, col, val,
// checksum on a byte valid/ready stream, then holds off for GAP_CYCLES cycles.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   send_en                         - enable; low blocks and aborts frames at a byte boundary
//   send_req                        - single-cycle frame request
//   row_index, col_index, pixel_val - frame payload, captured on acceptance
//   tx (master)                     - byte stream to the UART transmitter
//   busy                            - frame or gap in progress
//   frame_done, frame_abort         - one-cycle completion / abandon pulses
//   led_tx_on                       - combinational copy of send_en
//
// state   | meaning
// ST_IDLE | waiting for send_req with send_en high
// ST_SOF  | offering start-of-frame marker
// ST_ROW  | offering row byte
// ST_COL  | offering column byte
// ST_VAL  | offering pixel value byte
// ST_CSUM | offering checksum byte
// ST_GAP  | inter-frame gap countdown
module pixel_tx_framer
    import pixel_tx_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE   = SOF_DEFAULT,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      send_en,
    input  logic                      send_req,
    input  logic [7:0]                row_index,
    input  logic [7:0]                col_index,
    input  logic [7:0]                pixel_val,
    pixel_tx_framer_if.master         tx,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      frame_abort,
    output logic                      led_tx_on
);

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    state_t           state;
    state_t           state_d;
    logic [7:0]       row_q;
    logic [7:0]       col_q;
    logic [7:0]       val_q;
    logic [7:0]       csum_q;
    logic [GAP_W-1:0] gap_cnt;

    logic             hs;
    logic             accept;
    logic             payload_state;
    logic [7:0]       tx_data_d;
    logic             tx_valid_d;
    logic             busy_d;
    logic             done_d;
    logic             abort_d;

    assign hs            = tx.tx_valid && tx.tx_ready;
    assign accept        = (state == ST_IDLE) && send_req && send_en;
    assign payload_state = (state == ST_SOF) || (state == ST_ROW) ||
                           (state == ST_COL) || (state == ST_VAL);
    assign led_tx_on     = send_en;

    // Next state. send_en is only looked at on a handshake, so an offered
    // byte is never withdrawn; the checksum byte ignores it entirely.
    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE: if (accept) state_d = ST_SOF;
            ST_SOF:  if (hs) state_d = send_en ? ST_ROW  : ST_IDLE;
            ST_ROW:  if (hs) state_d = send_en ? ST_COL  : ST_IDLE;
            ST_COL:  if (hs) state_d = send_en ? ST_VAL  : ST_IDLE;
            ST_VAL:  if (hs) state_d = send_en ? ST_CSUM : ST_IDLE;
            ST_CSUM: if (hs) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:  if (gap_cnt == '0) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered outputs are driven from the state being entered, which
    // gives the one-cycle request-to-SOF latency and back-to-back bytes.
    always_comb begin
        tx_valid_d = 1'b0;
        tx_data_d  = tx.tx_data;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state == ST_CSUM) && hs;
        abort_d    = payload_state && hs && !send_en;
        unique case (state_d)
            ST_SOF:  begin tx_valid_d = 1'b1; tx_data_d = SOF_BYTE; end
            ST_ROW:  begin tx_valid_d = 1'b1; tx_data_d = row_q;    end
            ST_COL:  begin tx_valid_d = 1'b1; tx_data_d = col_q;    end
            ST_VAL:  begin tx_valid_d = 1'b1; tx_data_d = val_q;    end
            ST_CSUM: begin tx_valid_d = 1'b1; tx_data_d = csum_q;   end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tx.tx_data  <= 8'h00;
            tx.tx_valid <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
            row_q       <= 8'h00;
            col_q       <= 8'h00;
            val_q       <= 8'h00;
            csum_q      <= 8'h00;
        end else begin
            state       <= state_d;
            tx.tx_data  <= tx_data_d;
            tx.tx_valid <= tx_valid_d;
            busy        <= busy_d;
            frame_done  <= done_d;
            frame_abort <= abort_d;
            if (accept) begin
                row_q  <= row_index;
                col_q  <= col_index;
                val_q  <= pixel_val;
                csum_q <= frame_csum(SOF_BYTE, row_index, col_index, pixel_val);
            end
        end
    end

    // Loaded with GAP_CYCLES-1 so that, counting the frame_done cycle,
    // busy stays high for exactly GAP_CYCLES cycles after the last byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if ((state == ST_CSUM) && hs) begin
            gap_cnt <= GAP_LOAD;
        end else if ((state == ST_GAP) && (gap_cnt != '0)) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

endmodule

// File: tb/tb_pixel_tx_framer.sv
// tb_pixel_tx_framer: directed bench for pixel_tx_framer. Two instances share
// all stimulus: index 0 uses the default 16-cycle gap, index 1 has no gap.
// A frame-level model (byte list + gap countdown) predicts every output each
// cycle; literal expectations in the stimulus pin the model's behaviour.
module tb_pixel_tx_framer;

    logic       clk;
    logic       reset;
    logic       send_en;
    logic       send_req;
    logic [7:0] row_index;
    logic [7:0] col_index;
    logic [7:0] pixel_val;
    logic       tx_ready;

    logic busy16, done16, abort16, led16;
    logic busy0,  done0,  abort0,  led0;

    pixel_tx_framer_if bus16 ();
    pixel_tx_framer_if bus0 ();

    assign bus16.tx_ready = tx_ready;
    assign bus0.tx_ready  = tx_ready;

    pixel_tx_framer #(.SOF_BYTE(8'hA5), .GAP_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .send_en(send_en), .send_req(send_req),
        .row_index(row_index), .col_index(col_index), .pixel_val(pixel_val),
        .tx(bus16), .busy(busy16), .frame_done(done16), .frame_abort(abort16),
        .led_tx_on(led16)
    );

    pixel_tx_framer #(.SOF_BYTE(8'hA5), .GAP_CYCLES(0)) dut_nogap (
        .clk(clk), .reset(reset), .send_en(send_en), .send_req(send_req),
        .row_index(row_index), .col_index(col_index), .pixel_val(pixel_val),
        .tx(bus0), .busy(busy0), .frame_done(done0), .frame_abort(abort0),
        .led_tx_on(led0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    task automatic lchk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- frame-level model ----------------
    int         gcfg[2] = '{16, 0};
    logic       mv[2], mb[2], mdone[2], mab[2];
    logic [7:0] md[2];
    logic [7:0] mframe[2][5];
    int         midx[2];
    int         mgap[2];

    logic       d_valid[2], d_busy[2], d_done[2], d_abort[2], d_led[2];
    logic [7:0] d_data[2];
    assign d_valid[0] = bus16.tx_valid; assign d_valid[1] = bus0.tx_valid;
    assign d_data[0]  = bus16.tx_data;  assign d_data[1]  = bus0.tx_data;
    assign d_busy[0]  = busy16;         assign d_busy[1]  = busy0;
    assign d_done[0]  = done16;         assign d_done[1]  = done0;
    assign d_abort[0] = abort16;        assign d_abort[1] = abort0;
    assign d_led[0]   = led16;          assign d_led[1]   = led0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                mv[i] = 1'b0; md[i] = 8'h00; mb[i] = 1'b0;
                mdone[i] = 1'b0; mab[i] = 1'b0; mgap[i] = 0; midx[i] = 0;
            end else begin
                mdone[i] = 1'b0;
                mab[i]   = 1'b0;
                if (mv[i]) begin
                    if (tx_ready) begin
                        if (midx[i] == 4) begin
                            mv[i] = 1'b0; mdone[i] = 1'b1;
                            if (gcfg[i] == 0) mb[i] = 1'b0;
                            else mgap[i] = gcfg[i];
                        end else if (!send_en) begin
                            mv[i] = 1'b0; mab[i] = 1'b1; mb[i] = 1'b0;
                        end else begin
                            midx[i]++;
                            md[i] = mframe[i][midx[i]];
                        end
                    end
                end else if (mb[i]) begin
                    mgap[i]--;
                    if (mgap[i] == 0) mb[i] = 1'b0;
                end else if (send_req && send_en) begin
                    mframe[i][0] = 8'hA5;
                    mframe[i][1] = row_index;
                    mframe[i][2] = col_index;
                    mframe[i][3] = pixel_val;
                    mframe[i][4] = 8'hA5 ^ row_index ^ col_index ^ pixel_val;
                    midx[i] = 0; md[i] = 8'hA5; mv[i] = 1'b1; mb[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                lchk($sformatf("valid[%0d]", i), int'(d_valid[i]), int'(mv[i]));
                if (mv[i]) lchk($sformatf("data[%0d]", i), int'(d_data[i]), int'(md[i]));
                lchk($sformatf("busy[%0d]", i), int'(d_busy[i]), int'(mb[i]));
                lchk($sformatf("done[%0d]", i), int'(d_done[i]), int'(mdone[i]));
                lchk($sformatf("abort[%0d]", i), int'(d_abort[i]), int'(mab[i]));
                lchk($sformatf("led[%0d]", i), int'(d_led[i]), int'(send_en));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] got[$];
    logic [7:0] e1[5] = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'hD5};
    logic [7:0] e6[5] = '{8'hA5, 8'hFF, 8'h00, 8'hFF, 8'hA5};

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while ((busy16 || busy0) && n < 60) begin
            tick();
            @(negedge clk);
            n++;
        end
        lchk(name, int'(busy16 | busy0), 0);
        tick();
    endtask

    initial begin
        int n;
        int nv;
        int done_cnt;
        reset = 1'b1; send_en = 1'b1; send_req = 1'b0; tx_ready = 1'b1;
        row_index = 8'h00; col_index = 8'h00; pixel_val = 8'h00;
        tick();
        tick();
        chk_on = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        lchk("rst_data", int'(bus16.tx_data), 0);
        lchk("rst_valid", int'(bus16.tx_valid), 0);
        lchk("rst_busy", int'(busy16), 0);
        tick();

        // 1: back-to-back frame, then 16-cycle busy tail
        row_index = 8'h12; col_index = 8'h34; pixel_val = 8'h56; send_req = 1'b1;
        tick();
        send_req = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lchk("t1_byte", int'(bus16.tx_data), int'(e1[k]));
            lchk("t1_valid", int'(bus16.tx_valid), 1);
            tick();
        end
        @(negedge clk);
        lchk("t1_done", int'(done16), 1);
        lchk("t1_valid_off", int'(bus16.tx_valid), 0);
        n = 0;
        while (busy16 && n < 40) begin
            n++;
            tick();
            @(negedge clk);
        end
        lchk("t1_busy_len", n, 16);
        tick();

        // 2: sink stalls 3 cycles on the row byte
        send_req = 1'b1;
        tick();
        send_req = 1'b0;
        got.delete();
        nv = 0;
        for (int c = 0; c < 12; c++) begin
            tx_ready = !(c >= 1 && c <= 3);
            @(negedge clk);
            if (bus16.tx_valid) begin
                nv++;
                if (tx_ready) got.push_back(bus16.tx_data);
            end
            if (c >= 1 && c <= 4)
                lchk("t2_stall_row", int'({bus16.tx_valid, bus16.tx_data}), int'({1'b1, 8'h12}));
            tick();
        end
        tx_ready = 1'b1;
        lchk("t2_frame_len", nv, 8);
        lchk("t2_nbytes", got.size(), 5);
        for (int k = 0; k < 5; k++)
            if (k < got.size()) lchk("t2_byte", int'(got[k]), int'(e1[k]));
        wait_idle("t2_idle_timeout");

        // 3: send_en dropped at the col handshake, then immediate restart
        row_index = 8'h21; col_index = 8'h43; pixel_val = 8'h65; send_req = 1'b1;
        tick();
        send_req = 1'b0;
        tick();
        tick();
        send_en = 1'b0;
        @(negedge clk);
        lchk("t3_col", int'(bus16.tx_data), 8'h43);
        tick();
        send_en = 1'b1; send_req = 1'b1; row_index = 8'h0A;
        @(negedge clk);
        lchk("t3_valid_off", int'(bus16.tx_valid), 0);
        lchk("t3_abort", int'(abort16), 1);
        lchk("t3_busy", int'(busy16), 0);
        tick();
        send_req = 1'b0;
        @(negedge clk);
        lchk("t3_restart", int'({busy16, bus16.tx_valid, bus16.tx_data}), int'({2'b11, 8'hA5}));
        tick();
        wait_idle("t3_idle_timeout");

        // 4: requests mid-frame and during the gap are dropped
        row_index = 8'h31; col_index = 8'h32; pixel_val = 8'h33; send_req = 1'b1;
        tick();
        send_req = 1'b0;
        got.delete();
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            send_req  = (c == 2 || c == 10);
            row_index = (c >= 2) ? 8'h77 : 8'h31;
            @(negedge clk);
            if (bus16.tx_valid && tx_ready) got.push_back(bus16.tx_data);
            if (done16) done_cnt++;
            tick();
        end
        send_req = 1'b0;
        lchk("t4_nbytes", got.size(), 5);
        if (got.size() > 1) lchk("t4_row_kept", int'(got[1]), 8'h31);
        lchk("t4_done_cnt", done_cnt, 1);
        @(negedge clk);
        lchk("t4_idle", int'({busy16, bus16.tx_valid}), 0);
        tick();
        wait_idle("t4_idle_timeout");

        // 5: reset during the val byte
        row_index = 8'h44; col_index = 8'h55; pixel_val = 8'h66; send_req = 1'b1;
        tick();
        send_req = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        @(negedge clk);
        lchk("t5_val", int'(bus16.tx_data), 8'h66);
        tick();
        reset = 1'b0;
        @(negedge clk);
        lchk("t5_rst", int'({bus16.tx_data, bus16.tx_valid, busy16, done16, abort16}), 0);
        tick();
        tick();

        // 6: no-gap instance, two frames six cycles apart
        row_index = 8'hFF; col_index = 8'h00; pixel_val = 8'hFF;
        got.delete();
        for (int c = 0; c < 20; c++) begin
            send_req = (c == 0 || c == 6);
            @(negedge clk);
            if (bus0.tx_valid && tx_ready) got.push_back(bus0.tx_data);
            if (c == 6 || c == 12) begin
                lchk("t6_done", int'(done0), 1);
                lchk("t6_busy_low", int'(busy0), 0);
            end
            tick();
        end
        send_req = 1'b0;
        lchk("t6_nbytes", got.size(), 10);
        for (int k = 0; k < 10; k++)
            if (k < got.size()) lchk("t6_byte", int'(got[k]), int'(e6[k % 5]));
        wait_idle("t6_idle_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
